draw_canvas: RTL and testbench



---
 rtl/draw_canvas.sv | 153 +++++++++++++++
 tb/tb_draw_canvas.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_canvas.sv
// 28x28 binary drawing canvas: paints a 2x2 brush at the cursor once per frame and serves the
// cells to the VGA colour path (by screen position) and to software (by linear cell index).
module draw_canvas #(
  parameter int unsigned GRID      = 28,
  parameter int unsigned CELL_LOG2 = 3,
  parameter int unsigned ORG_X     = 208,
  parameter int unsigned ORG_Y     = 128
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       pen_down,
  input  logic       clear_req,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       in_canvas,
  output logic       pix_on,
  input  logic [9:0] rd_addr,
  output logic       rd_data,
  output logic       busy
);

  localparam int unsigned RowW   = $clog2(GRID);
  localparam int unsigned Span   = GRID << CELL_LOG2;
  localparam logic [9:0]  XLo    = 10'(ORG_X);
  localparam logic [9:0]  XHi    = 10'(ORG_X + Span);
  localparam logic [9:0]  YLo    = 10'(ORG_Y);
  localparam logic [9:0]  YHi    = 10'(ORG_Y + Span);
  localparam logic [9:0]  GridW  = 10'(GRID);
  localparam logic [9:0]  NCells = 10'(GRID * GRID);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_cnt_q, row_cnt_d;
  logic [GRID-1:0]   cells_q [GRID];
  logic [GRID-1:0]   cells_d [GRID];
  logic              fc_s1_q, fc_s2_q, fc_s3_q;
  logic              frame_tick;
  logic              in_canvas_q, pix_on_q, rd_data_q;

  // Third flop only remembers the previous synchronised level for edge detection.
  assign frame_tick = fc_s2_q & ~fc_s3_q;
  assign busy       = (state_q == StClear);

  // Cursor position in cell coordinates.
  logic       ball_in;
  logic [9:0] ball_col, ball_row;
  assign ball_in  = (BallX >= XLo) && (BallX < XHi) && (BallY >= YLo) && (BallY < YHi);
  assign ball_col = (BallX - XLo) >> CELL_LOG2;
  assign ball_row = (BallY - YLo) >> CELL_LOG2;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    cells_d   = cells_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          row_cnt_d = '0;
          state_d   = StClear;
        end else if (frame_tick && pen_down && ball_in) begin
          // Neighbours past the edge match no loop index, so they drop out without wrapping.
          for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
              if ((ball_row == 10'(r) || ball_row + 10'd1 == 10'(r)) &&
                  (ball_col == 10'(c) || ball_col + 10'd1 == 10'(c))) begin
                cells_d[r][c] = 1'b1;
              end
            end
          end
        end
      end
      StClear: begin
        for (int r = 0; r < GRID; r++) begin
          if (row_cnt_q == RowW'(r)) cells_d[r] = '0;
        end
        row_cnt_d = row_cnt_q + RowW'(1);
        if (row_cnt_q == RowW'(GRID - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Video lookup.
  logic            draw_in, draw_bit;
  logic [9:0]      draw_col, draw_row;
  logic [GRID-1:0] draw_bits;
  assign draw_in  = (DrawX >= XLo) && (DrawX < XHi) && (DrawY >= YLo) && (DrawY < YHi);
  assign draw_col = (DrawX - XLo) >> CELL_LOG2;
  assign draw_row = (DrawY - YLo) >> CELL_LOG2;

  always_comb begin
    draw_bits = '0;
    draw_bit  = 1'b0;
    for (int r = 0; r < GRID; r++) begin
      if (draw_row == 10'(r)) draw_bits = cells_q[r];
    end
    for (int c = 0; c < GRID; c++) begin
      if (draw_col == 10'(c)) draw_bit = draw_bits[c];
    end
  end

  // Software read port: linear index split into row/column by constant divide.
  logic            rd_in, rd_bit;
  logic [9:0]      rd_row, rd_col;
  logic [GRID-1:0] rd_bits;
  assign rd_in  = (rd_addr < NCells);
  assign rd_row = rd_addr / GridW;
  assign rd_col = rd_addr - rd_row * GridW;

  always_comb begin
    rd_bits = '0;
    rd_bit  = 1'b0;
    for (int r = 0; r < GRID; r++) begin
      if (rd_row == 10'(r)) rd_bits = cells_q[r];
    end
    for (int c = 0; c < GRID; c++) begin
      if (rd_col == 10'(c)) rd_bit = rd_bits[c];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      row_cnt_q   <= '0;
      fc_s1_q     <= 1'b0;
      fc_s2_q     <= 1'b0;
      fc_s3_q     <= 1'b0;
      in_canvas_q <= 1'b0;
      pix_on_q    <= 1'b0;
      rd_data_q   <= 1'b0;
      for (int r = 0; r < GRID; r++) cells_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      fc_s1_q     <= frame_clk;
      fc_s2_q     <= fc_s1_q;
      fc_s3_q     <= fc_s2_q;
      in_canvas_q <= draw_in;
      pix_on_q    <= draw_in & draw_bit;
      rd_data_q   <= rd_in & rd_bit;
      cells_q     <= cells_d;
    end
  end

  assign in_canvas = in_canvas_q;
  assign pix_on    = pix_on_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_draw_canvas.sv
// Directed self-checking bench for draw_canvas: paint, boundaries, clear sweep, video and SoC reads.
module tb_draw_canvas;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       pen_down = 1'b0;
  logic       clear_req = 1'b0;
  logic [9:0] BallX = '0, BallY = '0, DrawX = '0, DrawY = '0, rd_addr = '0;
  logic       in_canvas, pix_on, rd_data, busy;

  int checks = 0;
  int errors = 0;

  draw_canvas dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .pen_down (pen_down),
    .clear_req(clear_req),
    .BallX    (BallX),
    .BallY    (BallY),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .in_canvas(in_canvas),
    .pix_on   (pix_on),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    pen_down  = 1'b0;
    clear_req = 1'b0;
    frame_clk = 1'b0;
    Reset     = 1'b1;
    step(2);
    Reset = 1'b0;
    step(1);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    step(6);
    frame_clk = 1'b0;
    step(2);
  endtask

  task automatic paint(input int x, input int y);
    BallX    = 10'(x);
    BallY    = 10'(y);
    pen_down = 1'b1;
    frame_pulse();
    pen_down = 1'b0;
  endtask

  task automatic read_cell(input int a, output logic v);
    rd_addr = 10'(a);
    step(1);
    v = rd_data;
  endtask

  task automatic count_ones(output int n);
    logic v;
    n = 0;
    for (int a = 0; a < 784; a++) begin
      read_cell(a, v);
      if (v !== 1'b0) n++;
    end
  endtask

  task automatic test_reset();
    logic v;
    Reset = 1'b1;
    step(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pix_on !== 1'b0) begin errors++; $display("FAIL reset_pix_on: got %b want 0", pix_on); end
    checks++; if (in_canvas !== 1'b0) begin errors++; $display("FAIL reset_in_canvas: got %b want 0", in_canvas); end
    checks++; if (rd_data !== 1'b0) begin errors++; $display("FAIL reset_rd_data: got %b want 0", rd_data); end
    Reset = 1'b0;
    step(1);
    for (int a = 0; a < 784; a++) begin
      read_cell(a, v);
      checks++;
      if (v !== 1'b0) begin errors++; $display("FAIL reset_cell %0d: got %b want 0", a, v); end
    end
  endtask

  task automatic test_paint_origin();
    int   addrs [6];
    logic exp   [6];
    logic v;
    addrs = '{0, 1, 28, 29, 2, 56};
    exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    paint(208, 128);
    for (int i = 0; i < 6; i++) begin
      read_cell(addrs[i], v);
      checks++;
      if (v !== exp[i]) begin errors++; $display("FAIL origin_cell %0d: got %b want %b", addrs[i], v, exp[i]); end
    end
  endtask

  task automatic test_corner();
    int   addrs [9];
    logic exp   [9];
    logic v;
    addrs = '{783, 0, 27, 756, 782, 755, 55, 28, 0};
    exp   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    paint(424, 344);
    for (int i = 0; i < 6; i++) begin
      read_cell(addrs[i], v);
      checks++;
      if (v !== exp[i]) begin errors++; $display("FAIL corner_cell %0d: got %b want %b", addrs[i], v, exp[i]); end
    end
    // Top-right corner: column 27 painted, column wrap into next row must not happen.
    do_reset();
    paint(424, 128);
    exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 2; i < 9; i++) begin
      read_cell(addrs[i], v);
      checks++;
      if (v !== exp[i]) begin errors++; $display("FAIL edge_cell %0d: got %b want %b", addrs[i], v, exp[i]); end
    end
  endtask

  task automatic test_outside();
    int   n;
    logic v;
    do_reset();
    paint(100, 200);
    paint(432, 200);
    paint(300, 352);
    paint(300, 127);
    count_ones(n);
    checks++; if (n != 0) begin errors++; $display("FAIL outside_paint: got %0d set cells want 0", n); end
    BallX = 10'd300; BallY = 10'd200; pen_down = 1'b0;
    frame_pulse();
    count_ones(n);
    checks++; if (n != 0) begin errors++; $display("FAIL pen_up_paint: got %0d set cells want 0", n); end
    paint(431, 351);
    read_cell(783, v);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL inner_edge_cell 783: got %b want 1", v); end
  endtask

  task automatic test_clear();
    int   n;
    int   cyc;
    do_reset();
    paint(208, 128);
    paint(300, 200);
    count_ones(n);
    checks++; if (n != 8) begin errors++; $display("FAIL pre_clear_count: got %0d want 8", n); end
    BallX = 10'd208; BallY = 10'd128; pen_down = 1'b1;
    clear_req = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_before_clear: got %b want 0", busy); end
    step(1);
    clear_req = 1'b0;
    frame_clk = 1'b1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      clear_req = (cyc == 10);
      step(1);
    end
    clear_req = 1'b0;
    frame_clk = 1'b0;
    pen_down  = 1'b0;
    checks++; if (cyc != 28) begin errors++; $display("FAIL busy_cycles: got %0d want 28", cyc); end
    count_ones(n);
    checks++; if (n != 0) begin errors++; $display("FAIL post_clear_count: got %0d want 0", n); end

    // clear_req in the same cycle as frame_tick: the paint (row 20, addr 560) must be dropped.
    BallX = 10'd208; BallY = 10'd288; pen_down = 1'b1; rd_addr = 10'd560;
    frame_clk = 1'b1;
    step(2);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL collide_busy: got %b want 1", busy); end
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++;
      if (rd_data !== 1'b0) begin errors++; $display("FAIL collide_paint %0d: got %b want 0", i, rd_data); end
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; step(1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collide_busy_end: got %b want 0", busy); end
    frame_clk = 1'b0;
    pen_down  = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    logic v;
    do_reset();
    paint(208, 288);
    rd_addr   = 10'd560;
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    step(5);
    checks++; if (rd_data !== 1'b1) begin errors++; $display("FAIL partial_clear_read: got %b want 1", rd_data); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    checks++; if (rd_data !== 1'b0) begin errors++; $display("FAIL async_reset_rd: got %b want 0", rd_data); end
    step(1);
    Reset = 1'b0;
    read_cell(560, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_cell_560: got %b want 0", v); end
    read_cell(589, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_cell_589: got %b want 0", v); end
  endtask

  task automatic test_video();
    int   xs [9];
    int   ys [9];
    logic ein [9];
    logic eon [9];
    logic v;
    xs  = '{216, 224, 215, 215, 207, 432, 431, 208, 208};
    ys  = '{128, 128, 143, 144, 128, 128, 351, 127, 352};
    ein = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    eon = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    paint(208, 128);
    for (int x = 208; x < 216; x++) begin
      DrawX = 10'(x); DrawY = 10'd128;
      step(1);
      checks++;
      if (in_canvas !== 1'b1) begin errors++; $display("FAIL vid_in x=%0d: got %b want 1", x, in_canvas); end
      checks++;
      if (pix_on !== 1'b1) begin errors++; $display("FAIL vid_on x=%0d: got %b want 1", x, pix_on); end
    end
    for (int i = 0; i < 9; i++) begin
      DrawX = 10'(xs[i]); DrawY = 10'(ys[i]);
      step(1);
      checks++;
      if (in_canvas !== ein[i]) begin
        errors++; $display("FAIL vid_in (%0d,%0d): got %b want %b", xs[i], ys[i], in_canvas, ein[i]);
      end
      checks++;
      if (pix_on !== eon[i]) begin
        errors++; $display("FAIL vid_on (%0d,%0d): got %b want %b", xs[i], ys[i], pix_on, eon[i]);
      end
    end
    read_cell(900, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL rd_900: got %b want 0", v); end
    read_cell(784, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL rd_784: got %b want 0", v); end
    read_cell(29, v);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL rd_29: got %b want 1", v); end
  endtask

  task automatic test_back_to_back();
    int   addrs [10];
    logic exp   [10];
    logic v;
    addrs = '{0, 1, 28, 29, 30, 57, 58, 2, 56, 59};
    exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    paint(208, 128);
    paint(216, 136);
    for (int i = 0; i < 10; i++) begin
      read_cell(addrs[i], v);
      checks++;
      if (v !== exp[i]) begin errors++; $display("FAIL b2b_cell %0d: got %b want %b", addrs[i], v, exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_paint_origin();
    test_corner();
    test_outside();
    test_clear();
    test_reset_mid_clear();
    test_video();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
